nc_inv_chk_mc: RTL and testbench

- Multi-channel successor of the single-port non-cacheable-load/I$-invalidate checker.
- Watches NUM_CH CPX return channels in parallel (one per tile/core slice).
- Flags any load return (rtntype 4'b0000) carrying nc=1 and wv=1, i.e. a non-cacheable load that invalidates the I$.
- Adds post-reset holdoff, per-channel masking, saturating violation count, first-violation capture, threshold-based sticky fail and warn-only mode; outputs are registered for the monitor/fail hook in the bench top.

---
 rtl/nc_inv_chk_mc.sv | 174 +++++++++++++++++
 tb/tb_nc_inv_chk_mc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nc_inv_chk_mc.sv
// Multi-channel checker for non-cacheable load returns that also invalidate the I$.
// Detection has a post-reset holdoff, per-channel masking, a saturating count, first-hit capture and a sticky fail.
module nc_inv_chk_mc #(
    parameter int NUM_CH      = 8,
    parameter int CH_W        = 3,
    parameter int CORE_W      = 10,
    parameter int CNT_W       = 8,
    parameter int FAIL_THRESH = 1,
    parameter int HOLDOFF     = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NUM_CH-1:0]        cpxpkt_vld,
    input  logic [4*NUM_CH-1:0]      cpxpkt_rtntype,
    input  logic [NUM_CH-1:0]        nc,
    input  logic [NUM_CH-1:0]        wv,
    input  logic [CORE_W*NUM_CH-1:0] coreid,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     enable,
    input  logic                     warn_only,
    input  logic                     clr,
    output logic                     viol_vld,
    output logic [NUM_CH-1:0]        viol_vec,
    output logic [CH_W-1:0]          viol_ch,
    output logic [CORE_W-1:0]        viol_coreid,
    output logic [CNT_W-1:0]         viol_cnt,
    output logic                     first_vld,
    output logic [CH_W-1:0]          first_ch,
    output logic [CORE_W-1:0]        first_coreid,
    output logic                     fail
);

    localparam int HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam int SUM_W = CNT_W + CH_W + 1;
    localparam logic [HO_W-1:0]  HOLDOFF_INIT = HO_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0] CNT_MAX_EXT  = SUM_W'(CNT_MAX);
    localparam logic [SUM_W-1:0] THRESH_EXT   = SUM_W'(FAIL_THRESH);

    function automatic logic [CH_W:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CH_W:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + (CH_W + 1)'(v[i]);
        end
        return sum;
    endfunction

    logic [HO_W-1:0]   holdoff_r;
    logic [NUM_CH-1:0] hit_s;
    logic              any_hit_s;
    logic [CH_W-1:0]   lo_ch_s;
    logic [CORE_W-1:0] lo_cid_s;
    logic [CH_W:0]     pop_s;
    logic [CNT_W-1:0]  cnt_base_s;
    logic [SUM_W-1:0]  cnt_sum_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              fail_set_s;
    logic              fail_next_s;
    logic              first_vld_next_s;
    logic [CH_W-1:0]   first_ch_next_s;
    logic [CORE_W-1:0] first_cid_next_s;

    logic              viol_vld_r;
    logic [NUM_CH-1:0] viol_vec_r;
    logic [CH_W-1:0]   viol_ch_r;
    logic [CORE_W-1:0] viol_coreid_r;
    logic [CNT_W-1:0]  viol_cnt_r;
    logic              first_vld_r;
    logic [CH_W-1:0]   first_ch_r;
    logic [CORE_W-1:0] first_coreid_r;
    logic              fail_r;

    // Per-channel raw hit detection, gated by enable and the holdoff window
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_s[i] = cpxpkt_vld[i] & (cpxpkt_rtntype[4*i +: 4] == 4'b0000)
                     & nc[i] & wv[i] & ~ch_mask[i];
        end
        if (enable && (holdoff_r == '0)) begin
            hit_s = hit_s;
        end else begin
            hit_s = '0;
        end
    end

    // Lowest-index violating channel; scanning downward lets the lowest index win
    always_comb begin
        lo_ch_s  = '0;
        lo_cid_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            lo_ch_s  = hit_s[i] ? CH_W'(i) : lo_ch_s;
            lo_cid_s = hit_s[i] ? coreid[CORE_W*i +: CORE_W] : lo_cid_s;
        end
    end

    // Counter, capture and fail next-state; a clear restarts from zero but keeps this cycle's hits
    always_comb begin
        any_hit_s  = |hit_s;
        pop_s      = popcount(hit_s);
        cnt_base_s = clr ? '0 : viol_cnt_r;
        cnt_sum_s  = SUM_W'(cnt_base_s) + SUM_W'(pop_s);
        if (cnt_sum_s > CNT_MAX_EXT) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
        fail_set_s = ~warn_only & (SUM_W'(cnt_next_s) >= THRESH_EXT);
        if (clr) begin
            fail_next_s = fail_set_s;
        end else if (enable) begin
            fail_next_s = fail_r | fail_set_s;
        end else begin
            fail_next_s = fail_r;
        end
        first_vld_next_s = first_vld_r;
        first_ch_next_s  = first_ch_r;
        first_cid_next_s = first_coreid_r;
        if (clr) begin
            first_vld_next_s = any_hit_s;
            first_ch_next_s  = lo_ch_s;
            first_cid_next_s = lo_cid_s;
        end else if (!first_vld_r && any_hit_s) begin
            first_vld_next_s = 1'b1;
            first_ch_next_s  = lo_ch_s;
            first_cid_next_s = lo_cid_s;
        end else begin
            first_vld_next_s = first_vld_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            holdoff_r      <= HOLDOFF_INIT;
            viol_vld_r     <= 1'b0;
            viol_vec_r     <= '0;
            viol_ch_r      <= '0;
            viol_coreid_r  <= '0;
            viol_cnt_r     <= '0;
            first_vld_r    <= 1'b0;
            first_ch_r     <= '0;
            first_coreid_r <= '0;
            fail_r         <= 1'b0;
        end else begin
            if (holdoff_r != '0) begin
                holdoff_r <= holdoff_r - HO_W'(1);
            end else begin
                holdoff_r <= holdoff_r;
            end
            viol_vld_r     <= any_hit_s;
            viol_vec_r     <= hit_s;
            viol_ch_r      <= lo_ch_s;
            viol_coreid_r  <= lo_cid_s;
            viol_cnt_r     <= cnt_next_s;
            first_vld_r    <= first_vld_next_s;
            first_ch_r     <= first_ch_next_s;
            first_coreid_r <= first_cid_next_s;
            fail_r         <= fail_next_s;
        end
    end

    assign viol_vld     = viol_vld_r;
    assign viol_vec     = viol_vec_r;
    assign viol_ch      = viol_ch_r;
    assign viol_coreid  = viol_coreid_r;
    assign viol_cnt     = viol_cnt_r;
    assign first_vld    = first_vld_r;
    assign first_ch     = first_ch_r;
    assign first_coreid = first_coreid_r;
    assign fail         = fail_r;

endmodule

// File: tb/tb_nc_inv_chk_mc.sv
// Scoreboard bench for nc_inv_chk_mc: dut_a uses default parameters, dut_b uses FAIL_THRESH=3 and CNT_W=4.
module tb_nc_inv_chk_mc;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [7:0]  vld_in;
    logic [31:0] rt_in;
    logic [7:0]  nc_in;
    logic [7:0]  wv_in;
    logic [79:0] cid_in;
    logic [7:0]  ch_mask;
    logic        en_a, en_b, warn_only, clr;

    logic        a_vld, a_fv, a_fail, b_vld, b_fv, b_fail;
    logic [7:0]  a_vec, b_vec, a_cnt;
    logic [3:0]  b_cnt;
    logic [2:0]  a_ch, a_fch, b_ch, b_fch;
    logic [9:0]  a_cid, a_fcid, b_cid, b_fcid;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        bit         sel;
        string      nm;
        logic [44:0] bits;
    } exp_t;
    exp_t q[$];

    nc_inv_chk_mc dut_a (
        .clk(clk), .rst_l(rst_l), .cpxpkt_vld(vld_in), .cpxpkt_rtntype(rt_in),
        .nc(nc_in), .wv(wv_in), .coreid(cid_in), .ch_mask(ch_mask), .enable(en_a),
        .warn_only(warn_only), .clr(clr), .viol_vld(a_vld), .viol_vec(a_vec),
        .viol_ch(a_ch), .viol_coreid(a_cid), .viol_cnt(a_cnt), .first_vld(a_fv),
        .first_ch(a_fch), .first_coreid(a_fcid), .fail(a_fail)
    );

    nc_inv_chk_mc #(.CNT_W(4), .FAIL_THRESH(3)) dut_b (
        .clk(clk), .rst_l(rst_l), .cpxpkt_vld(vld_in), .cpxpkt_rtntype(rt_in),
        .nc(nc_in), .wv(wv_in), .coreid(cid_in), .ch_mask(ch_mask), .enable(en_b),
        .warn_only(warn_only), .clr(clr), .viol_vld(b_vld), .viol_vec(b_vec),
        .viol_ch(b_ch), .viol_coreid(b_cid), .viol_cnt(b_cnt), .first_vld(b_fv),
        .first_ch(b_fch), .first_coreid(b_fcid), .fail(b_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [44:0] act_bits(input bit sel);
        if (sel == 1'b0)
            return {a_vld, a_vec, a_ch, a_cid, a_cnt, a_fv, a_fch, a_fcid, a_fail};
        else
            return {b_vld, b_vec, b_ch, b_cid, {4'b0000, b_cnt}, b_fv, b_fch, b_fcid, b_fail};
    endfunction

    // Monitor: pops every expectation that falls due on this cycle and compares
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [44:0] act;
            e = q.pop_front();
            act = act_bits(e.sel);
            n_vec++;
            if (act !== e.bits || e.due != cyc) begin
                n_miss++;
                $display("FAIL %s dut_%s cyc %0d: got %h expected %h", e.nm,
                         e.sel ? "b" : "a", cyc, act, e.bits);
            end
        end
    end

    task automatic clear_in();
        vld_in = 8'h00; rt_in = 32'h0; nc_in = 8'h00; wv_in = 8'h00; cid_in = 80'h0;
    endtask

    task automatic set_ch(input int i, input logic [3:0] rt, input logic n, input logic w,
                          input logic [9:0] cid);
        vld_in[i] = 1'b1; rt_in[4*i +: 4] = rt; nc_in[i] = n; wv_in[i] = w;
        cid_in[10*i +: 10] = cid;
    endtask

    // Push the expected outputs for the cycle after these inputs are sampled, then advance
    task automatic chk(input string nm, input bit sel, input logic vld, input logic [7:0] vec,
                       input logic [2:0] ch, input logic [9:0] cid, input logic [7:0] cnt,
                       input logic fv, input logic [2:0] fch, input logic [9:0] fcid,
                       input logic fl);
        exp_t e;
        e.due  = cyc + 1;
        e.sel  = sel;
        e.nm   = nm;
        e.bits = {vld, vec, ch, cid, cnt, fv, fch, fcid, fl};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l = 1'b0; clear_in(); ch_mask = 8'h00;
        en_a = 1'b1; en_b = 1'b0; warn_only = 1'b0; clr = 1'b0;
        #22 rst_l = 1'b1;
        @(posedge clk);
        #1;
        // Inputs now are sampled on the 2nd posedge after release; holdoff reaches 0 at the 17th
        for (int p = 2; p <= 20; p++) begin
            clear_in();
            if (p == 5 || p == 20) set_ch(0, 4'b0000, 1'b1, 1'b1, 10'h03A);
            if (p == 20)
                chk("holdoff_hit", 1'b0, 1'b1, 8'h01, 3'd0, 10'h03A, 8'd1, 1'b1, 3'd0, 10'h03A, 1'b1);
            else if (p == 5)
                chk("holdoff_sup", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd0, 1'b0, 3'd0, 10'h000, 1'b0);
            else
                chk("holdoff_idle", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd0, 1'b0, 3'd0, 10'h000, 1'b0);
        end
        clear_in();
        chk("pulse_end", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd1, 1'b1, 3'd0, 10'h03A, 1'b1);
        clr = 1'b1;
        chk("clr_a", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd0, 1'b0, 3'd0, 10'h000, 1'b0);
        clr = 1'b0;
        set_ch(2, 4'b0001, 1'b1, 1'b1, 10'h002);
        set_ch(3, 4'b0000, 1'b0, 1'b1, 10'h003);
        set_ch(4, 4'b0000, 1'b1, 1'b0, 10'h004);
        chk("non_viol", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd0, 1'b0, 3'd0, 10'h000, 1'b0);
        clear_in();
        set_ch(5, 4'b0000, 1'b1, 1'b1, 10'h025);
        set_ch(1, 4'b0000, 1'b1, 1'b1, 10'h011);
        chk("simul", 1'b0, 1'b1, 8'h22, 3'd1, 10'h011, 8'd2, 1'b1, 3'd1, 10'h011, 1'b1);
        clear_in();
        chk("simul_end", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd2, 1'b1, 3'd1, 10'h011, 1'b1);
        set_ch(7, 4'b0000, 1'b1, 1'b1, 10'h3FF);
        chk("first_hold", 1'b0, 1'b1, 8'h80, 3'd7, 10'h3FF, 8'd3, 1'b1, 3'd1, 10'h011, 1'b1);
        clear_in();
        warn_only = 1'b1; clr = 1'b1;
        set_ch(6, 4'b0000, 1'b1, 1'b1, 10'h066);
        chk("clr_hit", 1'b0, 1'b1, 8'h40, 3'd6, 10'h066, 8'd1, 1'b1, 3'd6, 10'h066, 1'b0);
        clr = 1'b0; clear_in(); en_a = 1'b0;
        set_ch(0, 4'b0000, 1'b1, 1'b1, 10'h001);
        chk("disabled", 1'b0, 1'b0, 8'h00, 3'd0, 10'h000, 8'd1, 1'b1, 3'd6, 10'h066, 1'b0);

        // dut_b: threshold 3, 4-bit count
        en_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            clear_in();
            set_ch(3, 4'b0000, 1'b1, 1'b1, 10'h0C3);
            chk("warn_cnt", 1'b1, 1'b1, 8'h08, 3'd3, 10'h0C3, 8'(k), 1'b1, 3'd3, 10'h0C3, 1'b0);
        end
        clear_in(); warn_only = 1'b0;
        chk("warn_drop", 1'b1, 1'b0, 8'h00, 3'd0, 10'h000, 8'd4, 1'b1, 3'd3, 10'h0C3, 1'b1);
        clr = 1'b1;
        chk("clr_b", 1'b1, 1'b0, 8'h00, 3'd0, 10'h000, 8'd0, 1'b0, 3'd0, 10'h000, 1'b0);
        clr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            clear_in();
            set_ch(0, 4'b0000, 1'b1, 1'b1, 10'h001);
            chk("sat", 1'b1, 1'b1, 8'h01, 3'd0, 10'h001, 8'((k > 15) ? 15 : k), 1'b1, 3'd0,
                10'h001, (k >= 3) ? 1'b1 : 1'b0);
        end
        ch_mask = 8'h01;
        chk("masked", 1'b1, 1'b0, 8'h00, 3'd0, 10'h000, 8'd15, 1'b1, 3'd0, 10'h001, 1'b1);
        ch_mask = 8'h00;
        chk("burst", 1'b1, 1'b1, 8'h01, 3'd0, 10'h001, 8'd15, 1'b1, 3'd0, 10'h001, 1'b1);
        chk("burst", 1'b1, 1'b1, 8'h01, 3'd0, 10'h001, 8'd15, 1'b1, 3'd0, 10'h001, 1'b1);

        // Asynchronous reset while a pulse is showing and hits are still arriving
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            logic [44:0] act;
            act = act_bits(s[0]);
            n_vec++;
            if (act !== 45'h0) begin
                n_miss++;
                $display("FAIL async_rst dut_%s: got %h expected %h", (s == 0) ? "a" : "b",
                         act, 45'h0);
            end
        end
        q.delete();
        #10 rst_l = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
